result_writeback: RTL and testbench
===================================

RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 64, the width of one out_buffer row (8 PE results x 8 bit).
REQ-002 SHALL have parameter ROWS, default 8, the number of rows drained per matrix.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  when high, a start may be accepted.
REQ-006 start  in  1  one-cycle pulse: out_buffer holds a completed matrix.
REQ-007 clear  in  1  reloads the write pointer and clears sticky flags.
REQ-008 wb_base_addr  in  8  first BRAM result address.
REQ-009 wb_end_addr  in  8  last writable BRAM result address.
REQ-010 rd_out_buffer  out  1  out_buffer read strobe.
REQ-011 r_addr_out_buffer  out  4  out_buffer read address.
REQ-012 out_buffer_dout  in  DATA_W  out_buffer read data, valid one cycle after the strobe.
REQ-013 en_BRAM, wea_BRAM  out  1 each  BRAM enable and write enable.
REQ-014 addr_BRAM  out  8  BRAM address.
REQ-015 din_BRAM  out  DATA_W  BRAM write data.
REQ-016 busy  out  1  a drain is in progress.
REQ-017 done  out  1  one-cycle pulse at the end of a drain.
REQ-018 overflow  out  1  sticky: at least one row write was suppressed.
REQ-019 start_drop  out  1  sticky: a start arrived while busy.

Function
REQ-020 States SHALL be: IDLE, READ (issues ROWS reads), DRAIN (completes the write pipeline), DONE (one cycle, then IDLE).
REQ-021 Start acceptance SHALL occur in IDLE when start=1 and en=1, with T0 the accepting cycle.
- busy SHALL be high T1..T(ROWS+2).
REQ-022 In READ, rd_out_buffer SHALL be 1 during T1..T(ROWS).
- r_addr_out_buffer SHALL count ROWS down to 1 (8 at T1, 1 at T8).
- r_addr_out_buffer SHALL be 0 and the strobe low at all other times.
REQ-023 Data returned at T(k+1) SHALL be written to BRAM at T(k+2).
- en_BRAM=wea_BRAM=1, addr_BRAM=wr_ptr, din_BRAM=registered out_buffer_dout.
- Writes therefore occur at T3..T10, rows in order 8..1.
REQ-024 wr_ptr SHALL increment by 1 after each performed write and SHALL persist across drains, so consecutive matrices append.
REQ-025 A write at wr_ptr==wb_end_addr SHALL set an internal full flag.
- While full, writes SHALL be suppressed (en_BRAM=wea_BRAM=0), wr_ptr SHALL hold, and overflow SHALL be set.
- The drain timing SHALL be unchanged while full.
REQ-026 done SHALL pulse high for exactly one cycle at T(ROWS+3) (T11), after which the state is IDLE.
REQ-027 A start while not in IDLE SHALL be ignored and SHALL set start_drop.
- A start in IDLE with en=0 SHALL be ignored without setting any flag.
REQ-028 clear in IDLE SHALL load wr_ptr<=wb_base_addr and SHALL clear full, overflow and start_drop.
- clear and start in the same cycle: clear SHALL apply first, and the drain SHALL write from wb_base_addr.
- clear while busy SHALL be ignored.
REQ-029 en_BRAM, wea_BRAM, addr_BRAM and din_BRAM SHALL be 0 in every cycle without a write.
REQ-030 Once accepted, a drain SHALL complete regardless of en.
REQ-031 No wrap-around SHALL occur: addresses past 0xFF are unreachable because full saturates the pointer.

Reset
REQ-032 rst=1 at any posedge SHALL, at that edge, force:
- state IDLE;
- all outputs 0 (busy, done, overflow, start_drop, strobes, addresses, din_BRAM);
- full cleared;
- wr_ptr<=wb_base_addr.
REQ-033 Reset mid-drain SHALL abort the drain with no further BRAM writes.
REQ-034 Flags and strobes SHALL stay 0 until the next accepted start.

Verification
REQ-035 Basic drain: rst, base=0x40, end=0xFF, start@T0, dout for row r = {8{r}}.
- rd addr 8..1 at T1..T8.
- Writes (0x40,0x0808..), …, (0x47,0x0101..) at T3..T10.
- done@T11.
REQ-036 Back-to-back: a second start after done writes 0x48..0x4F; busy is low between the drains.
REQ-037 Overflow: base=0xFC, end=0xFD.
- Writes only at 0xFC and 0xFD (T3, T4).
- en_BRAM=0 for T5..T10, overflow=1, done still @T11.
REQ-038 Dropped start: start again at T5.
- Exactly 8 writes, start_drop=1, done@T11, no second drain.
REQ-039 Reset mid-drain: rst at T5.
- From T6 all outputs 0, no writes.
- A new start writes from wb_base_addr.
REQ-040 Clear: after one drain (wr_ptr=0x48), clear+start together.
- Writes at 0x40..0x47; overflow and start_drop are 0.

Source files
------------

// File: rtl/result_writeback.sv
// Drains ROWS rows of out_buffer into BRAM at an appending write pointer; done pulses ROWS+3 cycles after start.
// No backpressure: an accepted drain always runs to completion, extra starts are dropped and flagged.
module result_writeback #(
   parameter int DATA_W = 64,
   parameter int ROWS   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              start,
   input  logic              clear,
   input  logic [7:0]        wb_base_addr,
   input  logic [7:0]        wb_end_addr,
   output logic              rd_out_buffer,
   output logic [3:0]        r_addr_out_buffer,
   input  logic [DATA_W-1:0] out_buffer_dout,
   output logic              en_BRAM,
   output logic              wea_BRAM,
   output logic [7:0]        addr_BRAM,
   output logic [DATA_W-1:0] din_BRAM,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              start_drop
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [3:0] ROWS_L = 4'(ROWS);

   state_t     state;
   logic [7:0] wr_ptr;
   logic       full;
   logic       rd_d1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         wr_ptr            <= wb_base_addr;
         full              <= 1'b0;
         rd_d1             <= 1'b0;
         rd_out_buffer     <= 1'b0;
         r_addr_out_buffer <= 4'd0;
         en_BRAM           <= 1'b0;
         wea_BRAM          <= 1'b0;
         addr_BRAM         <= 8'd0;
         din_BRAM          <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         overflow          <= 1'b0;
         start_drop        <= 1'b0;
      end else begin
         en_BRAM   <= 1'b0;
         wea_BRAM  <= 1'b0;
         addr_BRAM <= 8'd0;
         din_BRAM  <= '0;
         done      <= 1'b0;
         rd_d1     <= rd_out_buffer;

         // rd_d1 marks the cycle the out_buffer data is valid; it lands in BRAM one cycle later
         if (rd_d1) begin
            if (!full) begin
               en_BRAM   <= 1'b1;
               wea_BRAM  <= 1'b1;
               addr_BRAM <= wr_ptr;
               din_BRAM  <= out_buffer_dout;
               if (wr_ptr == wb_end_addr)
                  full <= 1'b1;
               else
                  wr_ptr <= wr_ptr + 8'd1;
            end else begin
               overflow <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (clear) begin
                  wr_ptr     <= wb_base_addr;
                  full       <= 1'b0;
                  overflow   <= 1'b0;
                  start_drop <= 1'b0;
               end
               if (start && en) begin
                  state             <= READ;
                  busy              <= 1'b1;
                  rd_out_buffer     <= 1'b1;
                  r_addr_out_buffer <= ROWS_L;
               end
            end
            READ: begin
               if (start)
                  start_drop <= 1'b1;
               if (r_addr_out_buffer == 4'd1) begin
                  rd_out_buffer     <= 1'b0;
                  r_addr_out_buffer <= 4'd0;
                  state             <= DRAIN;
               end else begin
                  r_addr_out_buffer <= r_addr_out_buffer - 4'd1;
               end
            end
            DRAIN: begin
               if (start)
                  start_drop <= 1'b1;
               if (!rd_d1) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               if (start)
                  start_drop <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: cycle table for one drain, then multi-cycle corner sequences.
module tb_result_writeback;

   logic        clk = 1'b0;
   logic        rst, en, start, clear;
   logic [7:0]  wb_base_addr, wb_end_addr;
   logic        rd_out_buffer;
   logic [3:0]  r_addr_out_buffer;
   logic [63:0] out_buffer_dout;
   logic        en_BRAM, wea_BRAM;
   logic [7:0]  addr_BRAM;
   logic [63:0] din_BRAM;
   logic        busy, done, overflow, start_drop;

   int tests = 0;
   int fails = 0;

   logic [7:0]  wa[$];
   logic [63:0] wd[$];
   int          wt[$];
   int          done_t, post_err, idle_err;
   logic        busy0;

   typedef struct {
      logic        start;
      logic        rd;
      logic [3:0]  ra;
      logic        we;
      logic [7:0]  addr;
      logic [63:0] din;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t tbl [13];

   result_writeback #(.DATA_W(64), .ROWS(8)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .clear(clear),
      .wb_base_addr(wb_base_addr), .wb_end_addr(wb_end_addr),
      .rd_out_buffer(rd_out_buffer), .r_addr_out_buffer(r_addr_out_buffer),
      .out_buffer_dout(out_buffer_dout),
      .en_BRAM(en_BRAM), .wea_BRAM(wea_BRAM), .addr_BRAM(addr_BRAM), .din_BRAM(din_BRAM),
      .busy(busy), .done(done), .overflow(overflow), .start_drop(start_drop)
   );

   always #5 clk = ~clk;

   // out_buffer model: row r reads back as {8{r}}, one cycle after the strobe
   always @(posedge clk) begin
      if (rd_out_buffer)
         out_buffer_dout <= {8{4'h0, r_addr_out_buffer}};
      else
         out_buffer_dout <= 64'hA5A5_5A5A_C3C3_3C3C;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] row_pat(input int r);
      logic [7:0] b;
      b = 8'(r);
      return {8{b}};
   endfunction

   // one drain starting at T0; optional extra start and reset pulse; records every BRAM write
   task automatic run(input logic clr, input int drop_at, input int rst_at);
      wa.delete(); wd.delete(); wt.delete();
      done_t = -1; post_err = 0; idle_err = 0;
      for (int t = 0; t <= 14; t++) begin
         start = (t == 0) || (t == drop_at);
         en    = (t == 0) || (t == drop_at);
         clear = clr && (t == 0);
         rst   = (t == rst_at);
         if (t == 0) busy0 = busy;
         if (en_BRAM) begin
            wa.push_back(addr_BRAM);
            wd.push_back(din_BRAM);
            wt.push_back(t);
         end else if (wea_BRAM || addr_BRAM != 8'd0 || din_BRAM != 64'd0) begin
            idle_err++;
         end
         if (done && done_t < 0) done_t = t;
         if (rst_at >= 0 && t > rst_at &&
             (busy || done || rd_out_buffer || en_BRAM || wea_BRAM || overflow || start_drop ||
              r_addr_out_buffer != 4'd0 || addr_BRAM != 8'd0 || din_BRAM != 64'd0))
            post_err++;
         step();
      end
      start = 1'b0; en = 1'b0; clear = 1'b0; rst = 1'b0;
   endtask

   task automatic check_writes(input string tag, input int n, input logic [7:0] a0);
      check($sformatf("%s_nwrites", tag), 64'(wa.size()), 64'(n));
      check($sformatf("%s_idle_zero", tag), 64'(idle_err), 64'd0);
      for (int i = 0; i < wa.size() && i < n; i++) begin
         check($sformatf("%s_addr%0d", tag, i), 64'(wa[i]), 64'(a0 + 8'(i)));
         check($sformatf("%s_din%0d", tag, i), wd[i], row_pat(8 - i));
         check($sformatf("%s_cyc%0d", tag, i), 64'(wt[i]), 64'(i + 3));
      end
   endtask

   initial begin
      for (int t = 0; t < 13; t++) begin
         tbl[t].start = (t == 0);
         tbl[t].rd    = (t >= 1 && t <= 8);
         tbl[t].ra    = (t >= 1 && t <= 8) ? 4'(9 - t) : 4'd0;
         tbl[t].we    = (t >= 3 && t <= 10);
         tbl[t].addr  = (t >= 3 && t <= 10) ? 8'(8'h40 + t - 3) : 8'h00;
         tbl[t].din   = (t >= 3 && t <= 10) ? row_pat(11 - t) : 64'd0;
         tbl[t].busy  = (t >= 1 && t <= 10);
         tbl[t].done  = (t == 11);
      end

      rst = 1'b1; en = 1'b0; start = 1'b0; clear = 1'b0;
      wb_base_addr = 8'h40; wb_end_addr = 8'hFF;
      step(); step();
      rst = 1'b0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_start_drop", 64'(start_drop), 64'd0);
      check("rst_rd", 64'(rd_out_buffer), 64'd0);
      check("rst_raddr", 64'(r_addr_out_buffer), 64'd0);
      check("rst_en_bram", 64'(en_BRAM), 64'd0);
      check("rst_addr_bram", 64'(addr_BRAM), 64'd0);
      check("rst_din_bram", din_BRAM, 64'd0);

      // basic drain, cycle by cycle
      for (int t = 0; t < 13; t++) begin
         start = tbl[t].start;
         en    = tbl[t].start;
         check($sformatf("tbl_rd_T%0d", t), 64'(rd_out_buffer), 64'(tbl[t].rd));
         check($sformatf("tbl_raddr_T%0d", t), 64'(r_addr_out_buffer), 64'(tbl[t].ra));
         check($sformatf("tbl_en_T%0d", t), 64'(en_BRAM), 64'(tbl[t].we));
         check($sformatf("tbl_wea_T%0d", t), 64'(wea_BRAM), 64'(tbl[t].we));
         check($sformatf("tbl_addr_T%0d", t), 64'(addr_BRAM), 64'(tbl[t].addr));
         check($sformatf("tbl_din_T%0d", t), din_BRAM, tbl[t].din);
         check($sformatf("tbl_busy_T%0d", t), 64'(busy), 64'(tbl[t].busy));
         check($sformatf("tbl_done_T%0d", t), 64'(done), 64'(tbl[t].done));
         step();
      end
      start = 1'b0; en = 1'b0;

      // back-to-back drain appends
      run(1'b0, -1, -1);
      check("b2b_busy_between", 64'(busy0), 64'd0);
      check_writes("b2b", 8, 8'h48);
      check("b2b_done_t", 64'(done_t), 64'd11);

      // start with en low is ignored silently
      start = 1'b1; en = 1'b0;
      step();
      start = 1'b0;
      check("en0_busy", 64'(busy), 64'd0);
      check("en0_rd", 64'(rd_out_buffer), 64'd0);
      check("en0_start_drop", 64'(start_drop), 64'd0);
      step();

      // start while busy is dropped
      run(1'b0, 5, -1);
      check_writes("drop", 8, 8'h50);
      check("drop_start_drop", 64'(start_drop), 64'd1);
      check("drop_done_t", 64'(done_t), 64'd11);
      check("drop_busy_after", 64'(busy), 64'd0);

      // clear together with start restarts at base and clears flags
      run(1'b1, -1, -1);
      check_writes("clr", 8, 8'h40);
      check("clr_start_drop", 64'(start_drop), 64'd0);
      check("clr_overflow", 64'(overflow), 64'd0);

      // overflow near the end of the window
      wb_base_addr = 8'hFC; wb_end_addr = 8'hFD;
      rst = 1'b1; step(); rst = 1'b0;
      run(1'b0, -1, -1);
      check_writes("ovf", 2, 8'hFC);
      check("ovf_overflow", 64'(overflow), 64'd1);
      check("ovf_done_t", 64'(done_t), 64'd11);
      clear = 1'b1; step(); clear = 1'b0;
      check("ovf_clear_overflow", 64'(overflow), 64'd0);

      // reset in the middle of a drain
      wb_base_addr = 8'h40; wb_end_addr = 8'hFF;
      clear = 1'b1; step(); clear = 1'b0;
      run(1'b0, -1, 5);
      check_writes("rstmid", 3, 8'h40);
      check("rstmid_no_done", 64'(done_t), 64'hFFFF_FFFF_FFFF_FFFF);
      check("rstmid_quiet", 64'(post_err), 64'd0);
      run(1'b0, -1, -1);
      check_writes("rstmid_after", 8, 8'h40);
      check("rstmid_after_done_t", 64'(done_t), 64'd11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
